// File: rtl/gsim_resid.sv
// gsim_resid: residual checker r = M*x - (b<<16) for 16 rows; GSIM_RESID_SQERR_EN adds the sq_err output
module gsim_resid #(
    parameter logic [31:0] TOL = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [15:0] b_in,
    input  logic        x_valid,
    input  logic [31:0] x_in,
    output logic        r_valid,
    output logic [31:0] r_out,
    output logic [3:0]  r_idx,
    output logic        done,
    output logic        pass
`ifdef GSIM_RESID_SQERR_EN
    ,
    output logic [63:0] sq_err
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t             r_state, w_next;
    logic [4:0]         r_bcnt, r_xcnt;
    logic [3:0]         r_row;
    logic               r_ok;
    logic [15:0]        r_bm [16];
    logic [31:0]        r_xm [16];
    logic               w_load, w_bcap, w_xcap;
    logic [4:0]         w_bnext, w_xnext, w_i;
    logic [15:0]        w_b;
    logic signed [39:0] w_mx, w_r;
    logic [31:0]        w_sat;
    logic [32:0]        w_abs;

    // Indices below 0 or above 15 wrap into 16..31, so bit 4 marks out-of-range neighbours.
    function automatic logic signed [39:0] f_x(input logic [4:0] j);
        logic [31:0] v;
        v = r_xm[j[3:0]];
        return j[4] ? 40'sd0 : $signed({{8{v[31]}}, v});
    endfunction

    assign w_load  = (r_state == IDLE) || (r_state == LOAD);
    assign w_bcap  = w_load && in_en && !r_bcnt[4];
    assign w_xcap  = w_load && x_valid && !r_xcnt[4];
    assign w_bnext = r_bcnt + {4'd0, w_bcap};
    assign w_xnext = r_xcnt + {4'd0, w_xcap};
    assign w_i     = {1'b0, r_row};
    assign w_b     = r_bm[r_row];
    assign w_mx    = 40'sd20 * f_x(w_i)
                   - 40'sd13 * (f_x(w_i - 5'd1) + f_x(w_i + 5'd1))
                   + 40'sd6  * (f_x(w_i - 5'd2) + f_x(w_i + 5'd2))
                   - (f_x(w_i - 5'd3) + f_x(w_i + 5'd3));
    assign w_r     = w_mx - $signed({{8{w_b[15]}}, w_b, 16'h0000});
    assign w_sat   = (w_r[39:31] == '0 || w_r[39:31] == '1) ? w_r[31:0] :
                     (w_r[39] ? 32'h8000_0000 : 32'h7FFF_FFFF);
    assign w_abs   = w_sat[31] ? 33'd0 - {1'b1, w_sat} : {1'b0, w_sat};

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state: CALC starts once both vectors hold all 16 words
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_en || x_valid) w_next = LOAD;
            LOAD:    if (w_bnext[4] && w_xnext[4]) w_next = CALC;
            CALC:    if (r_row == 4'd15) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Word counters, row sequencing, registered residual outputs and pass flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcnt  <= '0;
            r_xcnt  <= '0;
            r_row   <= '0;
            r_ok    <= 1'b0;
            r_valid <= 1'b0;
            r_out   <= '0;
            r_idx   <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            r_bcnt  <= (r_state == DONE) ? 5'd0 : w_bnext;
            r_xcnt  <= (r_state == DONE) ? 5'd0 : w_xnext;
            r_valid <= (r_state == CALC);
            done    <= (r_state == DONE);
            if (r_state == LOAD && w_next == CALC) begin
                r_ok  <= 1'b1;
                r_row <= '0;
            end
            if (r_state == CALC) begin
                r_out <= w_sat;
                r_idx <= r_row;
                r_row <= r_row + 4'd1;
                r_ok  <= r_ok && (w_abs <= {1'b0, TOL});
            end
            if (r_state == DONE) pass <= r_ok;
        end
    end

    // Operand storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (!reset && w_bcap) r_bm[r_bcnt[3:0]] <= b_in;
        if (!reset && w_xcap) r_xm[r_xcnt[3:0]] <= x_in;
    end

`ifdef GSIM_RESID_SQERR_EN
    logic signed [63:0] w_s64;
    logic [63:0]        w_sq;
    logic [64:0]        w_acc;

    assign w_s64 = $signed({{32{w_sat[31]}}, w_sat});
    assign w_sq  = w_s64 * w_s64;
    assign w_acc = {1'b0, sq_err} + {1'b0, w_sq};

    // Saturating sum of squared saturated residuals, cleared on CALC entry
    always_ff @(posedge clk) begin
        if (reset)                                  sq_err <= '0;
        else if (r_state == LOAD && w_next == CALC) sq_err <= '0;
        else if (r_state == CALC)                   sq_err <= w_acc[64] ? '1 : w_acc[63:0];
    end
`endif

endmodule
